// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU MEM stage and the loader.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_LDR
  } gnt_e;

  localparam int DATA_W_DEF    = 32;
  localparam int BURST_MAX_DEF = 4;
  localparam int BURST_CNT_W   = 4;

endpackage

// File: rtl/dmem_arb_picker.sv
// Round-robin grant selection; define DMEM_ARB_LDR_BURST_EN to let a locked loader keep
// priority for up to BURST_MAX consecutive grants.
module dmem_arb_picker
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic ldr_lock,
  output gnt_e grant
);

  gnt_e rr_ptr_q, rr_ptr_d;
  logic ldr_hold;

`ifdef DMEM_ARB_LDR_BURST_EN
  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST_MAX);

  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // A burst only holds priority once the loader has already won a locked grant.
  assign ldr_hold = ldr_lock && (rr_ptr_q == GNT_LDR) &&
                    (burst_cnt_q != '0) && (burst_cnt_q < BURST_LIM);

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if ((grant == GNT_CPU) || !ldr_lock) begin
      burst_cnt_d = '0;
    end else if ((grant == GNT_LDR) && (burst_cnt_q < BURST_LIM)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign ldr_hold   = 1'b0;
  assign unused_cfg = ldr_lock | (BURST_MAX > 0);
`endif

  always_comb begin
    grant    = GNT_NONE;
    rr_ptr_d = rr_ptr_q;
    if (!rst) begin
      if (cpu_req && ldr_req) begin
        grant = (ldr_hold || (rr_ptr_q == GNT_CPU)) ? GNT_LDR : GNT_CPU;
      end else if (cpu_req) begin
        grant = GNT_CPU;
      end else if (ldr_req) begin
        grant = GNT_LDR;
      end
    end
    if (grant != GNT_NONE) begin
      rr_ptr_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= GNT_LDR;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter top: muxes the granted requester onto the memory port and registers
// loader read data. Optional loader burst lock is enabled by DMEM_ARB_LDR_BURST_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_DArb_cpuReq,
  input  logic              i_DArb_cpuWe,
  input  logic              i_DArb_cpuSByte,
  input  logic [DATA_W-1:0] i_DArb_cpuAddr,
  input  logic [DATA_W-1:0] i_DArb_cpuWData,
  output logic              o_DArb_cpuStall,
  output logic [DATA_W-1:0] o_DArb_cpuRData,
  input  logic              i_DArb_ldrReq,
  input  logic              i_DArb_ldrWe,
  input  logic              i_DArb_ldrSByte,
  input  logic [DATA_W-1:0] i_DArb_ldrAddr,
  input  logic [DATA_W-1:0] i_DArb_ldrWData,
  input  logic              i_DArb_ldrLock,
  output logic              o_DArb_ldrGnt,
  output logic [DATA_W-1:0] o_DArb_ldrRData,
  output logic              o_DArb_ldrValid,
  output logic              o_DArb_dMemWe,
  output logic              o_DArb_sByte,
  output logic [DATA_W-1:0] o_DArb_addr,
  output logic [DATA_W-1:0] o_DArb_wData,
  input  logic [DATA_W-1:0] i_DArb_rData
);

  gnt_e              grant;
  logic              ldr_valid_q, ldr_valid_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  dmem_arb_picker #(
    .BURST_MAX(BURST_MAX)
  ) u_picker (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (i_DArb_cpuReq),
    .ldr_req (i_DArb_ldrReq),
    .ldr_lock(i_DArb_ldrLock),
    .grant   (grant)
  );

  always_comb begin
    o_DArb_dMemWe = 1'b0;
    o_DArb_sByte  = 1'b0;
    o_DArb_addr   = '0;
    o_DArb_wData  = '0;
    case (grant)
      GNT_CPU: begin
        o_DArb_dMemWe = i_DArb_cpuWe;
        o_DArb_sByte  = i_DArb_cpuSByte;
        o_DArb_addr   = i_DArb_cpuAddr;
        o_DArb_wData  = i_DArb_cpuWData;
      end
      GNT_LDR: begin
        o_DArb_dMemWe = i_DArb_ldrWe;
        o_DArb_sByte  = i_DArb_ldrSByte;
        o_DArb_addr   = i_DArb_ldrAddr;
        o_DArb_wData  = i_DArb_ldrWData;
      end
      default: ;
    endcase
  end

  assign o_DArb_cpuStall = i_DArb_cpuReq && (grant != GNT_CPU);
  assign o_DArb_cpuRData = i_DArb_rData;
  assign o_DArb_ldrGnt   = (grant == GNT_LDR);
  assign o_DArb_ldrValid = ldr_valid_q;
  assign o_DArb_ldrRData = ldr_rdata_q;

  // Loader writes still pulse valid but leave the last read data in place.
  always_comb begin
    ldr_valid_d = (grant == GNT_LDR);
    ldr_rdata_d = ldr_rdata_q;
    if ((grant == GNT_LDR) && !i_DArb_ldrWe) begin
      ldr_rdata_d = i_DArb_rData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ldr_valid_q <= 1'b0;
      ldr_rdata_q <= '0;
    end else begin
      ldr_valid_q <= ldr_valid_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter; expectations follow DMEM_ARB_LDR_BURST_EN.
module tb_dmem_arbiter;

  localparam int G_N = 0;
  localparam int G_C = 1;
  localparam int G_L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sbyte;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        ldr_req, ldr_we, ldr_sbyte, ldr_lock;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        cpu_stall, ldr_gnt, ldr_valid, mem_we, mem_sbyte;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    string       tag;
    logic        stall;
    logic        gnt_l;
    logic        we;
    logic        sbyte;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cpu_rdata;
    logic        ldr_valid;
    logic [31:0] ldr_rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_valid;
  logic [31:0] m_rdata;
  int          burst_seq[7];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_DArb_cpuReq  (cpu_req),
    .i_DArb_cpuWe   (cpu_we),
    .i_DArb_cpuSByte(cpu_sbyte),
    .i_DArb_cpuAddr (cpu_addr),
    .i_DArb_cpuWData(cpu_wdata),
    .o_DArb_cpuStall(cpu_stall),
    .o_DArb_cpuRData(cpu_rdata),
    .i_DArb_ldrReq  (ldr_req),
    .i_DArb_ldrWe   (ldr_we),
    .i_DArb_ldrSByte(ldr_sbyte),
    .i_DArb_ldrAddr (ldr_addr),
    .i_DArb_ldrWData(ldr_wdata),
    .i_DArb_ldrLock (ldr_lock),
    .o_DArb_ldrGnt  (ldr_gnt),
    .o_DArb_ldrRData(ldr_rdata),
    .o_DArb_ldrValid(ldr_valid),
    .o_DArb_dMemWe  (mem_we),
    .o_DArb_sByte   (mem_sbyte),
    .o_DArb_addr    (mem_addr),
    .o_DArb_wData   (mem_wdata),
    .i_DArb_rData   (mem_rdata)
  );

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endfunction

  task automatic cpuIn(logic req, logic we, logic sb, logic [31:0] addr, logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_sbyte = sb; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic ldrIn(logic req, logic we, logic sb, logic [31:0] addr, logic [31:0] wd,
                       logic lock);
    ldr_req = req; ldr_we = we; ldr_sbyte = sb; ldr_addr = addr; ldr_wdata = wd;
    ldr_lock = lock;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "/stall"},     32'(cpu_stall), 32'(e.stall));
      chk({e.tag, "/ldrGnt"},    32'(ldr_gnt),   32'(e.gnt_l));
      chk({e.tag, "/dMemWe"},    32'(mem_we),    32'(e.we));
      chk({e.tag, "/sByte"},     32'(mem_sbyte), 32'(e.sbyte));
      chk({e.tag, "/addr"},      mem_addr,       e.addr);
      chk({e.tag, "/wData"},     mem_wdata,      e.wdata);
      chk({e.tag, "/cpuRData"},  cpu_rdata,      e.cpu_rdata);
      chk({e.tag, "/ldrValid"},  32'(ldr_valid), 32'(e.ldr_valid));
      chk({e.tag, "/ldrRData"},  ldr_rdata,      e.ldr_rdata);
    end
  endtask

  // Drive one cycle, queue its expected outputs, check at negedge, then advance the model.
  task automatic applyStimulus(string tag, logic r, logic [31:0] rdata, int g);
    exp_t e;
    rst       = r;
    mem_rdata = rdata;
    e.tag       = tag;
    e.stall     = cpu_req && (g != G_C);
    e.gnt_l     = (g == G_L);
    e.we        = 1'b0;
    e.sbyte     = 1'b0;
    e.addr      = '0;
    e.wdata     = '0;
    e.cpu_rdata = rdata;
    e.ldr_valid = m_valid;
    e.ldr_rdata = m_rdata;
    if (g == G_C) begin
      e.we = cpu_we; e.sbyte = cpu_sbyte; e.addr = cpu_addr; e.wdata = cpu_wdata;
    end else if (g == G_L) begin
      e.we = ldr_we; e.sbyte = ldr_sbyte; e.addr = ldr_addr; e.wdata = ldr_wdata;
    end
    exp_q.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_rdata = '0;
    end else begin
      m_valid = (g == G_L);
      if ((g == G_L) && !ldr_we) m_rdata = rdata;
    end
    #1;
  endtask

  initial begin
`ifdef DMEM_ARB_LDR_BURST_EN
    burst_seq = '{G_C, G_L, G_L, G_L, G_L, G_C, G_L};
`else
    burst_seq = '{G_C, G_L, G_C, G_L, G_C, G_L, G_C};
`endif
    rst = 1'b1;
    mem_rdata = '0;
    cpuIn(0, 0, 0, 0, 0);
    ldrIn(0, 0, 0, 0, 0, 0);
    m_valid = 1'b0;
    m_rdata = '0;
    @(posedge clk);
    #1;

    cpuIn(1, 0, 0, 32'h10, 0);
    ldrIn(1, 0, 0, 32'h20, 0, 0);
    applyStimulus("reset", 1'b1, 32'h1234_5678, G_N);

    applyStimulus("tie0", 1'b0, 32'h1111_0000, G_C);
    applyStimulus("tie1", 1'b0, 32'h1111_0001, G_L);
    applyStimulus("tie2", 1'b0, 32'h1111_0002, G_C);
    applyStimulus("tie3", 1'b0, 32'h1111_0003, G_L);

    cpuIn(0, 0, 0, 0, 0);
    ldrIn(0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 1'b0, 32'h0, G_N);

    cpuIn(1, 0, 0, 32'h100, 0);
    applyStimulus("cpuRd", 1'b0, 32'hDEAD_BEEF, G_C);
    cpuIn(1, 1, 1, 32'h101, 32'h77);
    applyStimulus("cpuWrB", 1'b0, 32'h0, G_C);

    cpuIn(0, 0, 0, 0, 0);
    ldrIn(1, 1, 1, 32'h203, 32'hA5, 0);
    applyStimulus("ldrWrB", 1'b0, 32'hCAFE_0000, G_L);
    ldrIn(0, 0, 0, 0, 0, 0);
    applyStimulus("ldrWrDone", 1'b0, 32'h0, G_N);

    cpuIn(1, 1, 0, 32'h300, 32'h55AA_0000);
    ldrIn(1, 0, 0, 32'h400, 0, 1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("burst%0d", i), 1'b0, 32'h2222_0000 + 32'(i), burst_seq[i]);
    end

    cpuIn(0, 0, 0, 0, 0);
    applyStimulus("lockLdr", 1'b0, 32'h3333_0000, G_L);
    cpuIn(1, 0, 0, 32'h500, 0);
    applyStimulus("midRst", 1'b1, 32'h3333_0001, G_N);
    cpuIn(0, 0, 0, 0, 0);
    ldrIn(0, 0, 0, 0, 0, 0);
    applyStimulus("postRst", 1'b0, 32'h0, G_N);
    cpuIn(1, 0, 0, 32'h600, 0);
    ldrIn(1, 0, 0, 32'h700, 0, 1);
    applyStimulus("rstTie0", 1'b0, 32'h4444_0000, G_C);
    applyStimulus("rstTie1", 1'b0, 32'h4444_0001, G_L);
    cpuIn(0, 0, 0, 0, 0);
    ldrIn(0, 0, 0, 0, 0, 0);
    applyStimulus("final", 1'b0, 32'h0, G_N);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
